rega_zone_sched: RTL and testbench

Irrigation zone scheduler for the automatic watering controller. It shares the single water tank and pump among `N_ZONES` irrigation zones in round-robin order, running one timed watering cycle per dry, enabled zone. It also enforces mutual exclusion with the fertiliser/cleaning tank sequencer through a request/busy pair. It sits between the soil/tank sensors and the zone valves/pump drivers, alongside the fertiliser mixing FSM.

---
 rtl/rega_pkg.sv | 25 ++
 rtl/rega_zone_sched_rr_picker.sv | 34 +++
 rtl/rega_zone_sched.sv | 132 +++++++++++++
 tb/tb_rega_zone_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation scheduler and fertiliser sequencer.
// State codes, default sizes and tank level conditions.
package rega_pkg;

    localparam int N_ZONES_DEF = 4;
    localparam int TIMER_W_DEF = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_PRIME  = 3'd2;
    localparam logic [2:0] S_WATER  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    // Both level sensors dry: nothing left to pump.
    function automatic logic tank_empty(input logic nv0, input logic nv1);
        return !nv0 && !nv1;
    endfunction

    // Both level sensors wet: tank refilled.
    function automatic logic tank_full(input logic nv0, input logic nv1);
        return nv0 && nv1;
    endfunction

endpackage

// File: rtl/rega_zone_sched_rr_picker.sv
// Round-robin priority encoder: first request strictly after `last`,
// wrapping modulo N.
module rr_picker
    import rega_pkg::*;
#(
    parameter int N = N_ZONES_DEF
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    // Pick the requester with the smallest rotated distance from last+1.
    always_comb begin
        int best;
        int d;
        best  = N;
        d     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - 1 - int'(last)) % N;
            if (req[i] && d < best) begin
                best  = d;
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rega_zone_sched.sv
// Irrigation zone scheduler: shares one tank and pump among the zones
// round-robin, one timed watering cycle per dry, enabled zone.
module rega_zone_sched
    import rega_pkg::*;
#(
    parameter int N_ZONES = N_ZONES_DEF,
    parameter int TIMER_W = TIMER_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [N_ZONES-1:0]         dry,
    input  logic [N_ZONES-1:0]         zone_en,
    input  logic                       Nv0,
    input  logic                       Nv1,
    input  logic                       tank_busy,
    input  logic [TIMER_W-1:0]         dur,
    output logic [N_ZONES-1:0]         valve,
    output logic                       pump,
    output logic                       tank_req,
    output logic [$clog2(N_ZONES)-1:0] active_zone,
    output logic                       zone_done,
    output logic                       fault
);

    localparam int ZW = $clog2(N_ZONES);

    logic [2:0]         state;
    logic [ZW-1:0]      last;
    logic [TIMER_W-1:0] cnt;
    logic [N_ZONES-1:0] elig;
    logic [N_ZONES-1:0] pick_oh;
    logic [ZW-1:0]      pick;
    logic               pick_ok;
    logic               z_ok;

    assign elig    = dry & zone_en;
    assign pick_oh = N_ZONES'(1) << pick;
    assign z_ok    = elig[active_zone];

    rr_picker #(
        .N(N_ZONES)
    ) u_pick (
        .req  (elig),
        .last (last),
        .idx  (pick),
        .valid(pick_ok)
    );

    // FSM, duration counter, round-robin pointer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            last        <= ZW'(N_ZONES - 1);
            active_zone <= '0;
            cnt         <= '0;
            valve       <= '0;
            pump        <= 1'b0;
            tank_req    <= 1'b0;
            zone_done   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            zone_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|elig && !tank_busy && Nv0) begin
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!pick_ok) begin
                        state <= S_IDLE;
                    end else begin
                        active_zone <= pick;
                        cnt         <= dur;
                        if (dur == '0) begin
                            last      <= pick;
                            zone_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            valve    <= pick_oh;
                            tank_req <= 1'b1;
                            state    <= S_PRIME;
                        end
                    end
                end
                S_PRIME: begin
                    if (tick) begin
                        pump  <= 1'b1;
                        state <= S_WATER;
                    end
                end
                S_WATER: begin
                    if (tank_empty(Nv0, Nv1)) begin
                        valve    <= '0;
                        pump     <= 1'b0;
                        tank_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= S_FAULT;
                    end else begin
                        if (tick && cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                        if ((tick && cnt == TIMER_W'(1)) || !z_ok) begin
                            pump  <= 1'b0;
                            state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (tick) begin
                        valve     <= '0;
                        tank_req  <= 1'b0;
                        zone_done <= 1'b1;
                        last      <= active_zone;
                        state     <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (tank_full(Nv0, Nv1)) begin
                        fault <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rega_zone_sched.sv
// Bench for rega_zone_sched: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_rega_zone_sched;

    localparam int N  = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic [N-1:0]  dry = 4'hF;
    logic [N-1:0]  zone_en = 4'hF;
    logic          Nv0 = 1'b1;
    logic          Nv1 = 1'b1;
    logic          tank_busy = 1'b0;
    logic [TW-1:0] dur = 8'd3;
    logic [N-1:0]  valve;
    logic          pump;
    logic          tank_req;
    logic [1:0]    active_zone;
    logic          zone_done;
    logic          fault;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    rega_zone_sched #(
        .N_ZONES(N),
        .TIMER_W(TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .dry        (dry),
        .zone_en    (zone_en),
        .Nv0        (Nv0),
        .Nv1        (Nv1),
        .tank_busy  (tank_busy),
        .dur        (dur),
        .valve      (valve),
        .pump       (pump),
        .tank_req   (tank_req),
        .active_zone(active_zone),
        .zone_done  (zone_done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Time base: one tick every 4 cycles, changed away from the clock edge.
    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        tick = (cyc % 4 == 0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_PICK, M_OPEN, M_RUN, M_DRAIN, M_DRY} mph_t;
    mph_t ph = M_IDLE;
    int   m_last = N - 1;
    int   m_zone = 0;
    int   m_left = 0;
    bit   m_done = 1'b0;

    function automatic bit wants(input logic [N-1:0] v, input int z);
        return ((v >> z) & 4'b0001) != 4'b0000;
    endfunction

    function automatic int rr_next(input int from, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (wants(v, (from + k) % N)) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] w;
        int p;
        w = dry & zone_en;
        m_done = 1'b0;
        case (ph)
            M_IDLE: if (w != 0 && !tank_busy && Nv0) ph = M_PICK;
            M_PICK: begin
                p = rr_next(m_last, w);
                if (p < 0) ph = M_IDLE;
                else begin
                    m_zone = p;
                    m_left = int'(dur);
                    if (m_left == 0) begin
                        m_last = p;
                        m_done = 1'b1;
                        ph = M_IDLE;
                    end else ph = M_OPEN;
                end
            end
            M_OPEN: if (tick) ph = M_RUN;
            M_RUN: begin
                if (!Nv0 && !Nv1) ph = M_DRY;
                else if (tick && m_left == 1) ph = M_DRAIN;
                else begin
                    if (tick) m_left--;
                    if (!wants(w, m_zone)) ph = M_DRAIN;
                end
            end
            M_DRAIN: if (tick) begin
                m_done = 1'b1;
                m_last = m_zone;
                ph = M_IDLE;
            end
            M_DRY: if (Nv0 && Nv1) ph = M_IDLE;
            default: ph = M_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            ph = M_IDLE;
            m_last = N - 1;
            m_zone = 0;
            m_left = 0;
            m_done = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare and bookkeeping ----------------
    int dq[$];
    int pt_q[$];
    int pt_cur = 0;
    bit vseen = 0;
    bit pseen = 0;

    initial forever begin
        bit open;
        @(negedge clk);
        open = (ph == M_OPEN || ph == M_RUN || ph == M_DRAIN);
        chk("valve", int'(valve), open ? (1 << m_zone) : 0);
        chk("pump", int'(pump), int'(ph == M_RUN));
        chk("tank_req", int'(tank_req), int'(open));
        chk("fault", int'(fault), int'(ph == M_DRY));
        chk("zone_done", int'(zone_done), int'(m_done));
        chk("active_zone", int'(active_zone), m_zone);
        if (zone_done) begin
            dq.push_back(int'(active_zone));
            pt_q.push_back(pt_cur);
            pt_cur = 0;
        end
        if (pump && tick) pt_cur++;
        if (valve != 0) vseen = 1'b1;
        if (pump) pseen = 1'b1;
    end

    function automatic int dq_at(input int i);
        return (i < dq.size()) ? dq[i] : -1;
    endfunction

    function automatic int pt_at(input int i);
        return (i < pt_q.size()) ? pt_q[i] : -1;
    endfunction

    task automatic wait_dones(input string nm, input int n, input int budget);
        int c;
        c = 0;
        while (dq.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk(nm, dq.size() >= n ? n : dq.size(), n);
    endtask

    task automatic wait_pump(input string nm, input int budget);
        int c;
        c = 0;
        while (!pump && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk(nm, int'(pump), 1);
    endtask

    task automatic at_drive();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        @(negedge clk);
        #1;
        chk("rst_valve", int'(valve), 0);
        chk("rst_pump", int'(pump), 0);
        chk("rst_req", int'(tank_req), 0);
        chk("rst_az", int'(active_zone), 0);
        chk("rst_fault", int'(fault), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // All zones dry, dur=3: served 0,1,2,3,0 with 3 pump ticks each.
        wait_dones("s1_timeout", 5, 400);
        at_drive();
        dry = 4'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s1_zone%0d", i), dq_at(i), (i == 4) ? 0 : i);
            chk($sformatf("s1_ticks%0d", i), pt_at(i), 3);
        end
        repeat (6) @(negedge clk);

        // Zone 1 only, dur=5, dry drops after 2 WATER ticks.
        dq.delete();
        pt_q.delete();
        pt_cur = 0;
        at_drive();
        dry = 4'b0010;
        dur = 8'd5;
        for (int c = 0; c < 200 && pt_cur < 2; c++) begin
            @(negedge clk);
            #1;
        end
        chk("s2_reach2", pt_cur, 2);
        at_drive();
        dry = 4'b0000;
        wait_dones("s2_timeout", 1, 60);
        chk("s2_zone", dq_at(0), 1);
        chk("s2_ticks", pt_at(0), 2);
        repeat (4) @(negedge clk);

        // tank_busy holds off zone 2; release starts service.
        dq.delete();
        at_drive();
        tank_busy = 1'b1;
        dry = 4'b0100;
        dur = 8'd2;
        repeat (20) @(negedge clk);
        #1;
        chk("s3_busy_req", int'(tank_req), 0);
        chk("s3_busy_valve", int'(valve), 0);
        at_drive();
        tank_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("s3_valve", int'(valve), 4);
        chk("s3_req", int'(tank_req), 1);
        at_drive();
        tank_busy = 1'b1;
        wait_dones("s3_timeout", 1, 80);
        chk("s3_zone", dq_at(0), 2);
        at_drive();
        dry = 4'b0000;
        tank_busy = 1'b0;
        repeat (4) @(negedge clk);

        // Tank runs dry on zone 3, refill, zone 3 retried.
        dq.delete();
        at_drive();
        dry = 4'b1000;
        dur = 8'd10;
        wait_pump("s4_pump_on", 60);
        at_drive();
        Nv0 = 1'b0;
        Nv1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("s4_fault", int'(fault), 1);
        chk("s4_valve", int'(valve), 0);
        chk("s4_pump", int'(pump), 0);
        repeat (8) @(negedge clk);
        at_drive();
        Nv0 = 1'b1;
        Nv1 = 1'b1;
        wait_dones("s4_timeout", 1, 300);
        chk("s4_zone", dq_at(0), 3);
        at_drive();
        dry = 4'b0000;
        repeat (4) @(negedge clk);

        // dur=0: bare done pulses, no valve or pump, zone 0 then 1.
        dq.delete();
        vseen = 1'b0;
        pseen = 1'b0;
        at_drive();
        dry = 4'b0011;
        dur = 8'd0;
        wait_dones("s5_timeout", 2, 50);
        at_drive();
        dry = 4'b0000;
        repeat (6) @(negedge clk);
        #1;
        chk("s5_zone0", dq_at(0), 0);
        chk("s5_zone1", dq_at(1), 1);
        chk("s5_count", dq.size(), 2);
        chk("s5_valve_seen", int'(vseen), 0);
        chk("s5_pump_seen", int'(pseen), 0);

        // Asynchronous reset mid-WATER, then restart at zone 0.
        at_drive();
        dry = 4'hF;
        dur = 8'd10;
        wait_pump("s6_pump_on", 60);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("s6_valve", int'(valve), 0);
        chk("s6_pump", int'(pump), 0);
        chk("s6_req", int'(tank_req), 0);
        dq.delete();
        repeat (2) @(posedge clk);
        #2;
        dur = 8'd1;
        reset = 1'b1;
        wait_dones("s6_timeout", 1, 100);
        chk("s6_zone", dq_at(0), 0);
        at_drive();
        dry = 4'h0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
